// File: rtl/count_chk_pkg.sv
// Shared types and default sizes for the counter-stream checker.
package count_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_ERR_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a clear in the same cycle as an increment leaves 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_VAL = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= W'(inc);
    end else if (inc && (q != MAX_VAL)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// Receive-side checker for an up-counter stream: acquires lock on the
// sequence, then reports skipped/corrupted values and counts wrap-arounds.
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOCK_CNT   = 2,
  parameter int ERR_W      = DEF_ERR_W,
  parameter int ALLOW_HOLD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count
);

  localparam int              MC_W     = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [MC_W-1:0]  LAST_ACQ = MC_W'(LOCK_CNT - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] prev, prev_n;
  logic [WIDTH-1:0] pred;
  logic [MC_W-1:0]  match_cnt, match_n;
  logic             err_n, wrap_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      match_cnt  <= '0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      match_cnt  <= match_n;
      err_pulse  <= err_n;
      wrap_pulse <= wrap_n;
    end
  end

  assign pred = prev + 1'b1;

  always_comb begin
    state_n = state;
    prev_n  = prev;
    match_n = match_cnt;
    err_n   = 1'b0;
    wrap_n  = 1'b0;
    if (in_valid) begin
      prev_n = count_in;
      case (state)
        IDLE: begin
          match_n = '0;
          state_n = ACQ;
        end
        ACQ: begin
          if (count_in == pred) begin
            match_n = match_cnt + 1'b1;
            if (match_cnt == LAST_ACQ) state_n = LOCKED;
          end else begin
            match_n = '0;
          end
        end
        LOCKED: begin
          if (count_in == pred) begin
            wrap_n = (prev == MAX_VAL);
          end else if ((ALLOW_HOLD != 0) && (count_in == prev)) begin
            // stalled counter: legal, no event
          end else begin
            err_n   = 1'b1;
            match_n = '0;
            state_n = ACQ;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign locked = (state == LOCKED);

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (err_n),
    .q   (err_count)
  );

  sat_counter #(.W(ERR_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (wrap_n),
    .q   (wrap_count)
  );

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker (WIDTH=4, LOCK_CNT=2, ERR_W=8, ALLOW_HOLD=1).
module tb_count_seq_checker;
  import count_chk_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] count_in = '0;
  logic       clear = 1'b0;
  logic       locked, err_pulse, wrap_pulse;
  logic [7:0] err_count, wrap_count;

  int checks = 0;
  int errors = 0;

  count_seq_checker #(
    .WIDTH(4), .LOCK_CNT(2), .ERR_W(8), .ALLOW_HOLD(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .count_in   (count_in),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then settle #1 after the edge for sampling.
  task automatic step(input logic v, input logic [3:0] c, input logic clr);
    in_valid = v;
    count_in = c;
    clear    = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic lk, input logic ep, input logic wp,
                         input logic [7:0] ec, input logic [7:0] wc);
    chk({tag, "_locked"}, 32'(locked), 32'(lk));
    chk({tag, "_err_pulse"}, 32'(err_pulse), 32'(ep));
    chk({tag, "_wrap_pulse"}, 32'(wrap_pulse), 32'(wp));
    chk({tag, "_err_count"}, 32'(err_count), 32'(ec));
    chk({tag, "_wrap_count"}, 32'(wrap_count), 32'(wc));
  endtask

  initial begin
    logic [3:0] v;
    // 1: reset, then lock on 0,1,2
    rst = 1'b1;
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    chk_all("reset", 0, 0, 0, 0, 0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    step(1'b1, 4'd0, 1'b0);  chk("t1_s0_locked", 32'(locked), 0);
    step(1'b1, 4'd1, 1'b0);  chk("t1_s1_locked", 32'(locked), 0);
    step(1'b1, 4'd2, 1'b0);  chk_all("t1_s2", 1, 0, 0, 0, 0);

    // 2: run up to 15, wrap to 0
    for (int i = 3; i <= 15; i++) begin
      step(1'b1, 4'(i), 1'b0);
      chk_all($sformatf("t2_run%0d", i), 1, 0, 0, 0, 0);
    end
    step(1'b1, 4'd0, 1'b0);  chk_all("t2_wrap", 1, 0, 1, 0, 1);
    step(1'b1, 4'd1, 1'b0);  chk_all("t2_after_wrap", 1, 0, 0, 0, 1);

    // 3: skip from 5 to 9, relock on 10,11
    for (int i = 2; i <= 5; i++) step(1'b1, 4'(i), 1'b0);
    chk("t3_locked_at5", 32'(locked), 1);
    step(1'b1, 4'd9, 1'b0);  chk_all("t3_skip", 0, 1, 0, 1, 1);
    step(1'b1, 4'd10, 1'b0); chk_all("t3_s10", 0, 0, 0, 1, 1);
    step(1'b1, 4'd11, 1'b0); chk_all("t3_s11", 1, 0, 0, 1, 1);

    // 4: holds and an idle gap
    for (int i = 12; i <= 15; i++) step(1'b1, 4'(i), 1'b0);
    for (int i = 0; i <= 3; i++) step(1'b1, 4'(i), 1'b0);
    chk_all("t4_at3", 1, 0, 0, 1, 2);
    step(1'b1, 4'd3, 1'b0);  chk_all("t4_hold1", 1, 0, 0, 1, 2);
    step(1'b1, 4'd3, 1'b0);  chk_all("t4_hold2", 1, 0, 0, 1, 2);
    step(1'b1, 4'd4, 1'b0);  chk_all("t4_s4", 1, 0, 0, 1, 2);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'd9, 1'b0);
      chk_all($sformatf("t4_gap%0d", i), 1, 0, 0, 1, 2);
    end
    step(1'b1, 4'd5, 1'b0);  chk_all("t4_resume", 1, 0, 0, 1, 2);

    // 5: 300 mismatches, each followed by a relock
    v = 4'd5;
    for (int i = 0; i < 300; i++) begin
      v = v + 4'd3;
      step(1'b1, v, 1'b0);
      chk($sformatf("t5_err_pulse%0d", i), 32'(err_pulse), 1);
      v = v + 4'd1;
      step(1'b1, v, 1'b0);
      v = v + 4'd1;
      step(1'b1, v, 1'b0);
      chk($sformatf("t5_relock%0d", i), 32'(locked), 1);
    end
    chk_all("t5_sat", 1, 0, 0, 255, 2);
    step(1'b1, v + 4'd7, 1'b1);
    chk_all("t5_clear_mismatch", 0, 1, 0, 1, 0);
    v = v + 4'd7;

    // 6: build err_count=3 while locked, then reset (overriding clear/valid)
    for (int k = 0; k < 2; k++) begin
      v = v + 4'd1; step(1'b1, v, 1'b0);
      v = v + 4'd1; step(1'b1, v, 1'b0);
      v = v + 4'd6; step(1'b1, v, 1'b0);
    end
    v = v + 4'd1; step(1'b1, v, 1'b0);
    v = v + 4'd1; step(1'b1, v, 1'b0);
    chk_all("t6_pre_reset", 1, 0, 0, 3, 0);
    rst = 1'b1;
    step(1'b1, v + 4'd5, 1'b1);
    rst = 1'b0;
    chk_all("t6_reset", 0, 0, 0, 0, 0);
    chk("t6_state", 32'(dut.state), 32'(IDLE));
    step(1'b1, 4'd7, 1'b0);  chk_all("t6_s7", 0, 0, 0, 0, 0);
    step(1'b1, 4'd8, 1'b0);  chk_all("t6_s8", 0, 0, 0, 0, 0);
    step(1'b1, 4'd9, 1'b0);  chk_all("t6_s9", 1, 0, 0, 0, 0);

    // clear alone with no sample
    step(1'b1, 4'd2, 1'b0);  chk_all("t7_err", 0, 1, 0, 1, 0);
    step(1'b0, 4'd0, 1'b1);  chk_all("t7_clear", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
